rem_req_scheduler: RTL and testbench

- Shares one combinational `remainder` unit between two requesters (0 = keypad front-end, 1 = host/test port).
- Round-robin arbitration; accepts one operation at a time over valid/ready.
- Registers operands, result and flags, and returns them on a single tagged response channel.
- Keeps a saturating count of divide-by-zero events for status readout.

---
 rtl/calc_pkg.sv | 34 +++
 rtl/remainder.sv | 27 ++
 rtl/rem_req_scheduler.sv | 131 +++++++++++++
 tb/tb_rem_req_scheduler.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared types and constants for the remainder scheduler.
package calc_pkg;

    localparam int unsigned DATA_W = 3;

    // Divisor values the remainder unit treats as divide-by-zero, and the
    // remainder it reports in that case.
    localparam logic [DATA_W-1:0] DIV_ZERO_A = 3'b000;
    localparam logic [DATA_W-1:0] DIV_ZERO_B = 3'b100;

    localparam logic REQ_KEYPAD = 1'b0;
    localparam logic REQ_HOST   = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        RESP
    } state_t;

    // Result produced by the remainder unit.
    typedef struct packed {
        logic [DATA_W-1:0] r;
        logic              sf;
        logic              zf;
        logic              dzf;
    } calc_res_t;

    // Tagged response payload.
    typedef struct packed {
        logic      id;
        calc_res_t res;
    } rsp_t;

endpackage

// File: rtl/remainder.sv
// Combinational 3-bit unsigned remainder with sign/zero/divide-by-zero flags.
module remainder
    import calc_pkg::*;
(
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output calc_res_t         res_c_o
);

    logic [DATA_W-1:0] r;

    // Divisors 0 and 4 are both reported as divide-by-zero with all other flags clear.
    always_comb begin
        r       = '0;
        res_c_o = '0;
        if (b_i == '0 || b_i == DIV_ZERO_B) begin
            res_c_o.dzf = 1'b1;
            res_c_o.r   = DIV_ZERO_A;
        end else begin
            r           = a_i % b_i;
            res_c_o.r   = r;
            res_c_o.sf  = a_i[DATA_W-1];
            res_c_o.zf  = (r == '0);
        end
    end

endmodule

// File: rtl/rem_req_scheduler.sv
// Round-robin scheduler sharing one remainder unit between two requesters.
module rem_req_scheduler
    import calc_pkg::*;
#(
    parameter int unsigned DZ_CNT_W = 8,
    parameter int unsigned RR_INIT  = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req0_valid,
    input  logic [DATA_W-1:0]   req0_a,
    input  logic [DATA_W-1:0]   req0_b,
    output logic                req0_ready,
    input  logic                req1_valid,
    input  logic [DATA_W-1:0]   req1_a,
    input  logic [DATA_W-1:0]   req1_b,
    output logic                req1_ready,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_id,
    output logic [DATA_W-1:0]   rsp_r,
    output logic                rsp_sf,
    output logic                rsp_zf,
    output logic                rsp_dzf,
    output logic                busy,
    output logic [DZ_CNT_W-1:0] dz_count
);

    state_t              state_q, state_d;
    logic                ptr_q, ptr_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic                id_q, id_d;
    rsp_t                rsp_q, rsp_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DZ_CNT_W-1:0] dz_q, dz_d;
    calc_res_t           calc_res;

    // Shared arithmetic, fed only from the latched operands.
    remainder u_remainder (
        .a_i     (a_q),
        .b_i     (b_q),
        .res_c_o (calc_res)
    );

    // State, pointer, operand, response and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= 1'(RR_INIT);
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= 1'b0;
            rsp_q       <= '0;
            rsp_valid_q <= 1'b0;
            dz_q        <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            a_q         <= a_d;
            b_q         <= b_d;
            id_q        <= id_d;
            rsp_q       <= rsp_d;
            rsp_valid_q <= rsp_valid_d;
            dz_q        <= dz_d;
        end
    end

    // Arbitration, next-state and datapath updates.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        a_d         = a_q;
        b_d         = b_q;
        id_d        = id_q;
        rsp_d       = rsp_q;
        rsp_valid_d = rsp_valid_q;
        dz_d        = dz_q;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;

        case (state_q)
            IDLE: begin
                // Ready is held low while reset is asserted so no output leaks a grant.
                req0_ready = !rst && req0_valid && (!req1_valid || ptr_q == REQ_KEYPAD);
                req1_ready = !rst && req1_valid && (!req0_valid || ptr_q == REQ_HOST);
                if (req0_ready) begin
                    a_d     = req0_a;
                    b_d     = req0_b;
                    id_d    = REQ_KEYPAD;
                    ptr_d   = REQ_HOST;
                    state_d = CALC;
                end else if (req1_ready) begin
                    a_d     = req1_a;
                    b_d     = req1_b;
                    id_d    = REQ_HOST;
                    ptr_d   = REQ_KEYPAD;
                    state_d = CALC;
                end
            end
            CALC: begin
                rsp_d.id    = id_q;
                rsp_d.res   = calc_res;
                rsp_valid_d = 1'b1;
                if (calc_res.dzf && dz_q != '1) begin
                    dz_d = dz_q + DZ_CNT_W'(1);
                end
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_q.id;
    assign rsp_r     = rsp_q.res.r;
    assign rsp_sf    = rsp_q.res.sf;
    assign rsp_zf    = rsp_q.res.zf;
    assign rsp_dzf   = rsp_q.res.dzf;
    assign busy      = (state_q != IDLE);
    assign dz_count  = dz_q;

endmodule

// File: tb/tb_rem_req_scheduler.sv
// Directed self-checking bench for rem_req_scheduler.
module tb_rem_req_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req1_valid, rsp_ready;
    logic [2:0] req0_a, req0_b, req1_a, req1_b;

    logic       req0_ready, req1_ready, rsp_valid, rsp_id, rsp_sf, rsp_zf, rsp_dzf, busy;
    logic [2:0] rsp_r;
    logic [7:0] dz_count;

    logic       s_req0_ready, s_req1_ready, s_rsp_valid, s_rsp_id, s_rsp_sf, s_rsp_zf, s_rsp_dzf, s_busy;
    logic [2:0] s_rsp_r;
    logic [1:0] s_dz_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rem_req_scheduler #(.DZ_CNT_W(8), .RR_INIT(0)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_r(rsp_r),
        .rsp_sf(rsp_sf), .rsp_zf(rsp_zf), .rsp_dzf(rsp_dzf), .busy(busy), .dz_count(dz_count)
    );

    rem_req_scheduler #(.DZ_CNT_W(2), .RR_INIT(0)) dut_sat (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(s_req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(s_req1_ready),
        .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(s_rsp_id), .rsp_r(s_rsp_r),
        .rsp_sf(s_rsp_sf), .rsp_zf(s_rsp_zf), .rsp_dzf(s_rsp_dzf), .busy(s_busy), .dz_count(s_dz_count)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        req0_valid = 1'b0; req0_a = 3'd0; req0_b = 3'd0;
        req1_valid = 1'b0; req1_a = 3'd0; req1_b = 3'd0;
        rsp_ready  = 1'b0;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        clear_inputs;
        rst = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        rsp_ready  = 1'b1;
        tick;
        tick;
        checks++;
        if ({rsp_valid, rsp_id, rsp_r, rsp_sf, rsp_zf, rsp_dzf, busy, req0_ready, req1_ready} !== 11'b0) begin
            errors++;
            $display("FAIL reset_outputs got %b exp %b",
                     {rsp_valid, rsp_id, rsp_r, rsp_sf, rsp_zf, rsp_dzf, busy, req0_ready, req1_ready}, 11'b0);
        end
        checks++;
        if (dz_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_dz_count got %0d exp 0", dz_count);
        end
        clear_inputs;
        rst = 1'b0;
        tick;
    endtask

    task automatic test_basic;
        req0_valid = 1'b1; req0_a = 3'd7; req0_b = 3'd3; rsp_ready = 1'b1;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++;
            $display("FAIL basic_grant got %b exp 10", {req0_ready, req1_ready});
        end
        tick;
        req0_valid = 1'b0;
        checks++;
        if ({busy, rsp_valid, req0_ready} !== 3'b100) begin
            errors++;
            $display("FAIL basic_calc got %b exp 100", {busy, rsp_valid, req0_ready});
        end
        tick;
        checks++;
        if ({rsp_valid, rsp_id, rsp_r, rsp_sf, rsp_zf, rsp_dzf} !== {1'b1, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL basic_rsp got %b exp %b",
                     {rsp_valid, rsp_id, rsp_r, rsp_sf, rsp_zf, rsp_dzf}, {1'b1, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0});
        end
        tick;
        checks++;
        if ({busy, rsp_valid} !== 2'b00) begin
            errors++;
            $display("FAIL basic_done got %b exp 00", {busy, rsp_valid});
        end
    endtask

    task automatic test_div_zero;
        for (int k = 0; k < 2; k++) begin
            req1_valid = 1'b1; req1_a = 3'd5; req1_b = (k == 0) ? 3'd0 : 3'd4; rsp_ready = 1'b1;
            #1;
            checks++;
            if ({req0_ready, req1_ready} !== 2'b01) begin
                errors++;
                $display("FAIL dz_grant%0d got %b exp 01", k, {req0_ready, req1_ready});
            end
            tick;
            req1_valid = 1'b0;
            tick;
            checks++;
            if ({rsp_valid, rsp_id, rsp_r, rsp_sf, rsp_zf, rsp_dzf} !== {1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1}) begin
                errors++;
                $display("FAIL dz_rsp%0d got %b exp %b", k,
                         {rsp_valid, rsp_id, rsp_r, rsp_sf, rsp_zf, rsp_dzf}, {1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1});
            end
            checks++;
            if (dz_count !== 8'(k + 1)) begin
                errors++;
                $display("FAIL dz_count%0d got %0d exp %0d", k, dz_count, k + 1);
            end
            tick;
        end
    endtask

    task automatic test_round_robin;
        clear_inputs;
        do_reset;
        req0_valid = 1'b1; req0_a = 3'd6; req0_b = 3'd2;
        req1_valid = 1'b1; req1_a = 3'd3; req1_b = 3'd2;
        rsp_ready  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            logic       first;
            logic [1:0] exp_rdy;
            logic [4:0] exp_rsp;
            first   = ((k % 2) == 0);
            exp_rdy = first ? 2'b10 : 2'b01;
            exp_rsp = first ? {1'b0, 3'd0, 1'b1} : {1'b1, 3'd1, 1'b0};
            #1;
            checks++;
            if ({req0_ready, req1_ready} !== exp_rdy) begin
                errors++;
                $display("FAIL rr_grant%0d got %b exp %b", k, {req0_ready, req1_ready}, exp_rdy);
            end
            tick;
            tick;
            checks++;
            if ({rsp_id, rsp_r, rsp_zf} !== exp_rsp || rsp_valid !== 1'b1) begin
                errors++;
                $display("FAIL rr_rsp%0d got %b/%b exp %b/1", k, {rsp_id, rsp_r, rsp_zf}, rsp_valid, exp_rsp);
            end
            tick;
        end
        clear_inputs;
    endtask

    task automatic test_backpressure;
        req0_valid = 1'b1; req0_a = 3'd4; req0_b = 3'd3; rsp_ready = 1'b0;
        #1;
        tick;
        // Change every requester input after acceptance; the result must not move.
        req0_valid = 1'b0; req0_a = 3'd0; req0_b = 3'd0;
        req1_valid = 1'b1; req1_a = 3'd2; req1_b = 3'd1;
        tick;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({rsp_valid, rsp_id, rsp_r, rsp_sf, busy, req0_ready, req1_ready} !== {1'b1, 1'b0, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL bp_hold%0d got %b exp %b", i,
                         {rsp_valid, rsp_id, rsp_r, rsp_sf, busy, req0_ready, req1_ready},
                         {1'b1, 1'b0, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0});
            end
            tick;
        end
        req1_valid = 1'b0;
        rsp_ready  = 1'b1;
        tick;
        checks++;
        if ({rsp_valid, busy} !== 2'b00) begin
            errors++;
            $display("FAIL bp_release got %b exp 00", {rsp_valid, busy});
        end
    endtask

    task automatic test_reset_mid;
        clear_inputs;
        req1_valid = 1'b1; req1_a = 3'd3; req1_b = 3'd0;
        #1;
        tick;
        req1_valid = 1'b0;
        tick;
        checks++;
        if ({rsp_valid, rsp_dzf, dz_count} !== {1'b1, 1'b1, 8'd1}) begin
            errors++;
            $display("FAIL mid_pre got %b exp %b", {rsp_valid, rsp_dzf, dz_count}, {1'b1, 1'b1, 8'd1});
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({rsp_valid, busy, dz_count} !== 10'b0) begin
            errors++;
            $display("FAIL mid_rst got %b exp 0", {rsp_valid, busy, dz_count});
        end
        tick;
        rst = 1'b0;
        req0_valid = 1'b1; req0_a = 3'd5; req0_b = 3'd3; rsp_ready = 1'b1;
        #1;
        tick;
        req0_valid = 1'b0;
        tick;
        checks++;
        if ({rsp_valid, rsp_id, rsp_r, rsp_sf, rsp_zf, rsp_dzf} !== {1'b1, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL mid_after got %b exp %b",
                     {rsp_valid, rsp_id, rsp_r, rsp_sf, rsp_zf, rsp_dzf}, {1'b1, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0});
        end
        tick;
    endtask

    task automatic test_saturation;
        int exp_sat [5];
        exp_sat = '{1, 2, 3, 3, 3};
        clear_inputs;
        do_reset;
        rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            req1_valid = 1'b1; req1_a = 3'(k); req1_b = 3'd0;
            #1;
            tick;
            req1_valid = 1'b0;
            tick;
            checks++;
            if (s_dz_count !== 2'(exp_sat[k]) || s_rsp_valid !== 1'b1) begin
                errors++;
                $display("FAIL sat%0d got %0d/%b exp %0d/1", k, s_dz_count, s_rsp_valid, exp_sat[k]);
            end
            tick;
        end
        clear_inputs;
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs;
        test_reset;
        test_basic;
        test_div_zero;
        test_round_robin;
        test_backpressure;
        test_reset_mid;
        test_saturation;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end

endmodule
